// File: rtl/packed_word_pkg.sv
// Shared types for the packed word assembler and its output FIFO.
// word_t is the record handed to the downstream packed-struct consumer.
package packed_word_pkg;

  localparam int FIELD_W = 8;
  localparam int WORD_W  = 2 * FIELD_W;

  typedef struct packed {
    logic [FIELD_W-1:0] high;
    logic [FIELD_W-1:0] low;
  } word_t;

  typedef logic [WORD_W-1:0] word_mask_t;

  typedef enum logic {
    LANE_LOW  = 1'b0,
    LANE_HIGH = 1'b1
  } lane_e;

  // ST_EMIT is never held in the state register; it marks the accepting cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_EMIT    = 2'd2
  } acc_state_e;

  typedef struct packed {
    word_t      word;
    word_mask_t mask;
    logic       ovw;
  } fifo_entry_t;

  localparam word_mask_t MASK_FULL = '1;

endpackage

// File: rtl/packed_word_fifo.sv
// Small output FIFO of {word, mask, ovw} entries with separate occupancy count.
// Storage is cleared on reset so the head reads as zero until the first push.
module packed_word_fifo
  import packed_word_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/packed_word_assembler.sv
// Merges nibble-enabled byte-lane beats into 16-bit word_t records, tracking
// a per-bit written mask and a sticky overwrite flag, and queues finished words.
module packed_word_assembler
  import packed_word_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_lane,
  input  logic [1:0]  in_nib_en,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [15:0] out_mask,
  output logic        out_ovw,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a word transfers where out_valid && out_ready. Payloads hold while stalled.

  acc_state_e          state_q, state_d;
  logic [WORD_W-1:0]   acc_q, acc_d, acc_m;
  word_mask_t          mask_q, mask_d, mask_m;
  logic                ovw_q, ovw_d, ovw_m;
  logic [3:0]          lane_base;
  logic                accept;
  logic                emit;
  logic                fifo_full;
  logic                fifo_empty;
  fifo_entry_t         push_entry;
  fifo_entry_t         head;

  assign lane_base = (lane_e'(in_lane) == LANE_HIGH) ? 4'(FIELD_W) : 4'd0;
  assign accept    = in_valid && in_ready;

  // Merge the beat onto the accumulator; completion is judged on this result.
  always_comb begin
    acc_m  = acc_q;
    mask_m = mask_q;
    ovw_m  = ovw_q;
    for (int n = 0; n < 2; n++) begin
      if (in_nib_en[n]) begin
        acc_m[lane_base + 4'(4 * n) +: 4] = in_data[4 * n +: 4];
        if (mask_q[lane_base + 4'(4 * n) +: 4] != 4'h0) begin
          ovw_m = 1'b1;
        end
        mask_m[lane_base + 4'(4 * n) +: 4] = 4'hF;
      end
    end
  end

  assign emit = accept && ((mask_m == MASK_FULL) || (in_last && (mask_m != '0)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    ovw_d   = ovw_q;
    case (state_q)
      ST_IDLE, ST_PARTIAL: begin
        if (emit) begin
          acc_d   = '0;
          mask_d  = '0;
          ovw_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (accept) begin
          acc_d   = acc_m;
          mask_d  = mask_m;
          ovw_d   = ovw_m;
          state_d = (mask_m == '0) ? ST_IDLE : ST_PARTIAL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mask_q  <= '0;
      ovw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      ovw_q   <= ovw_d;
    end
  end

  assign push_entry = {acc_m, mask_m, ovw_m};

  packed_word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (emit),
    .push_data_i(push_entry),
    .pop_i      (out_valid && out_ready),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign in_ready    = !rst && !fifo_full;
  assign out_valid   = !fifo_empty;
  assign out_word    = head.word;
  assign out_mask    = head.mask;
  assign out_ovw     = head.ovw;
  assign dbg_state_o = emit ? ST_EMIT : state_q;

endmodule

// File: tb/tb_packed_word_assembler.sv
// Bench for packed_word_assembler: directed cases plus random beats checked
// against a nibble-level model feeding an expected-word queue.
module tb_packed_word_assembler;
  import packed_word_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_lane;
  logic [1:0]  in_nib_en;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [15:0] out_mask;
  logic        out_ovw;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic [3:0]  m_nib[4];
  bit          m_wr[4];
  bit          m_ovw;

  logic rand_phase = 1'b0;
  logic rnd_ready  = 1'b0;
  logic dir_ready  = 1'b1;

  assign out_ready = rand_phase ? rnd_ready : dir_ready;

  packed_word_assembler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_lane    (in_lane),
    .in_nib_en  (in_nib_en),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_mask   (out_mask),
    .out_ovw    (out_ovw),
    .dbg_state_o(dbg_state)
  );

  // Clock and random consumer readiness
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: four nibble slots, word emitted when all written or on last
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = 4'h0;
      m_wr[i]  = 1'b0;
    end
    m_ovw = 1'b0;
  endtask

  task automatic model_beat(input logic lane, input logic [1:0] en,
                            input logic [7:0] data, input logic last);
    logic [15:0] w;
    logic [15:0] m;
    bit all_wr;
    bit any_wr;
    for (int n = 0; n < 2; n++) begin
      if (en[n]) begin
        int k;
        k = (lane ? 2 : 0) + n;
        if (m_wr[k]) m_ovw = 1'b1;
        m_wr[k]  = 1'b1;
        m_nib[k] = data[n*4 +: 4];
      end
    end
    all_wr = m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3];
    any_wr = m_wr[0] || m_wr[1] || m_wr[2] || m_wr[3];
    if (all_wr || (last && any_wr)) begin
      w = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      m = {{4{m_wr[3]}}, {4{m_wr[2]}}, {4{m_wr[1]}}, {4{m_wr[0]}}};
      exp_q.push_back({w, m, m_ovw});
      model_reset();
    end
  endtask

  // Scoreboard: every valid head is compared with the oldest expected word
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", out_valid, 1'b0);
      end else begin
        mon_e = exp_q[0];
        check("out_word", out_word, mon_e[32:17]);
        check("out_mask", out_mask, mon_e[16:1]);
        check("out_ovw", out_ovw, mon_e[0]);
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: called at posedge+1, returns at posedge+1 after acceptance
  task automatic send_beat(input logic lane, input logic [1:0] en,
                           input logic [7:0] data, input logic last);
    int waited;
    in_valid  = 1'b1;
    in_lane   = lane;
    in_nib_en = en;
    in_data   = data;
    in_last   = last;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(lane, en, data, last);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_lane   = 1'b0;
    in_nib_en = 2'b00;
    in_data   = 8'h00;
    in_last   = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_word", out_word, 16'h0000);
    check("rst_out_mask", out_mask, 16'h0000);
    check("rst_out_ovw", out_ovw, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1'b1);

    // Two full-byte beats, single-cycle output pulse
    send_beat(LANE_LOW, 2'b11, 8'h00, 1'b0);
    send_beat(LANE_HIGH, 2'b11, 8'hFF, 1'b0);
    @(negedge clk);
    check("t1_valid_latency", out_valid, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_valid_pulse_end", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Nibble-only beats with last
    send_beat(LANE_HIGH, 2'b01, 8'hAF, 1'b0);
    @(negedge clk);
    check("t2_state_partial", dbg_state, ST_PARTIAL);
    @(posedge clk);
    #1;
    send_beat(LANE_LOW, 2'b01, 8'h50, 1'b1);
    wait_drain("t2_drain");

    // Overwrite sets the sticky flag
    send_beat(LANE_LOW, 2'b11, 8'h12, 1'b0);
    send_beat(LANE_LOW, 2'b10, 8'h30, 1'b0);
    send_beat(LANE_HIGH, 2'b11, 8'h7F, 1'b0);
    wait_drain("t3_drain");

    // Backpressure: fill both entries, third word stalls until a pop
    dir_ready = 1'b0;
    send_beat(LANE_LOW, 2'b11, 8'($urandom), 1'b0);
    send_beat(LANE_HIGH, 2'b11, 8'($urandom), 1'b0);
    send_beat(LANE_LOW, 2'b11, 8'($urandom), 1'b0);
    send_beat(LANE_HIGH, 2'b11, 8'($urandom), 1'b0);
    @(negedge clk);
    check("t4_full_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    fork
      begin
        send_beat(LANE_LOW, 2'b11, 8'($urandom), 1'b0);
        send_beat(LANE_HIGH, 2'b11, 8'($urandom), 1'b0);
      end
      begin
        repeat (2) begin
          @(negedge clk);
          check("t4_stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        dir_ready = 1'b1;
        @(negedge clk);
        check("t4_still_full", in_ready, 1'b0);
        @(negedge clk);
        check("t4_ready_after_pop", in_ready, 1'b1);
      end
    join
    wait_drain("t4_drain");

    // Empty last while idle pushes nothing
    send_beat(LANE_LOW, 2'b00, 8'h5A, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t5_no_valid", out_valid, 1'b0);
      check("t5_idle", dbg_state, ST_IDLE);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a partial word
    send_beat(LANE_HIGH, 2'b11, 8'hAA, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_word", out_word, 16'h0000);
    check("t6_rst_mask", out_mask, 16'h0000);
    check("t6_rst_ovw", out_ovw, 1'b0);
    check("t6_rst_in_ready", in_ready, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    send_beat(LANE_LOW, 2'b11, 8'h55, 1'b1);
    wait_drain("t6_drain");

    // Random beats with random consumer stalls
    rand_phase = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send_beat(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom), ($urandom_range(0, 4) == 0));
    end
    rand_phase = 1'b0;
    dir_ready  = 1'b1;
    wait_drain("rand_drain");
    @(negedge clk);
    check("final_empty", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
